// File: rtl/rpn_eval.sv
// rtl/rpn_eval.sv - postfix expression evaluator with operand stack and multi-cycle POW
module rpn_eval #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_kind,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_ACCEPT, S_POW, S_DONE} state_t;

    state_t           r_state;
    logic             r_tok_ready;
    logic             r_res_valid;
    logic             r_res_err;
    logic [WIDTH-1:0] r_res_data;
    logic [SW-1:0]    r_sp;
    logic             r_err;
    logic [WIDTH-1:0] r_stk [DEPTH];
    logic [WIDTH-1:0] r_pa;
    logic [WIDTH-1:0] r_pb;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic             w_xfer;
    logic [4:0]       w_op;
    logic [IW-1:0]    w_i1;
    logic [IW-1:0]    w_i2;
    logic [IW-1:0]    w_i3;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic [SW-1:0]    w_need;
    logic             w_bad_tok;
    logic             w_exec;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_sq;
    logic [WIDTH-1:0] w_pow_n;
    logic             w_wr_en;
    logic [IW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_wr_data;

    function automatic logic [WIDTH-1:0] f_bool(input logic x);
        return {{(WIDTH-1){1'b0}}, x};
    endfunction

    assign tok_ready = r_tok_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;

    assign w_xfer = tok_valid & r_tok_ready;
    assign w_op   = tok_data[4:0];
    assign w_i1   = r_sp[IW-1:0] - IW'(1);
    assign w_i2   = r_sp[IW-1:0] - IW'(2);
    assign w_i3   = r_sp[IW-1:0] - IW'(3);
    assign w_b    = r_stk[w_i1];
    assign w_a    = r_stk[w_i2];
    assign w_c    = r_stk[w_i3];

    always_comb begin
        w_need = SW'(1);
        if (w_op <= 5'd21)
            w_need = SW'(2);
        else if (w_op == 5'd22)
            w_need = SW'(3);
    end

    assign w_bad_tok = (tok_kind == 2'd3) ||
                       (tok_kind == 2'd1 && (w_op > 5'd25 || r_sp < w_need)) ||
                       (tok_kind == 2'd0 && r_sp == SW'(DEPTH));
    assign w_exec    = w_xfer && !r_err && tok_kind != 2'd2 && !w_bad_tok;

    always_comb begin
        w_alu = '0;
        case (w_op)
            5'd1:        w_alu = w_a * w_b;
            5'd2:        w_alu = w_a + w_b;
            5'd3:        w_alu = w_a - w_b;
            5'd4, 5'd5:  w_alu = w_a >> w_b;
            5'd6, 5'd7:  w_alu = w_a << w_b;
            5'd8:        w_alu = f_bool(w_a < w_b);
            5'd9:        w_alu = f_bool(w_a <= w_b);
            5'd10:       w_alu = f_bool(w_a > w_b);
            5'd11:       w_alu = f_bool(w_a >= w_b);
            5'd12, 5'd14: w_alu = f_bool(w_a == w_b);
            5'd13, 5'd15: w_alu = f_bool(w_a != w_b);
            5'd16:       w_alu = w_a & w_b;
            5'd17:       w_alu = w_a ^ w_b;
            5'd18:       w_alu = w_a ~^ w_b;
            5'd19:       w_alu = w_a | w_b;
            5'd20:       w_alu = f_bool((w_a != '0) && (w_b != '0));
            5'd21:       w_alu = f_bool((w_a != '0) || (w_b != '0));
            5'd22:       w_alu = (w_c != '0) ? w_a : w_b;
            5'd23:       w_alu = -w_b;
            5'd24:       w_alu = f_bool(&w_b);
            5'd25:       w_alu = f_bool(|w_b);
            default:     w_alu = '0;
        endcase
    end

    // MSB-first square-and-multiply: one exponent bit per POW cycle
    assign w_sq    = r_acc * r_acc;
    assign w_pow_n = r_pb[r_cnt] ? w_sq * r_pa : w_sq;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_sp[IW-1:0];
        w_wr_data = w_alu;
        if (r_state == S_POW && r_cnt == '0) begin
            w_wr_en   = 1'b1;
            w_wr_data = w_pow_n;
        end else if (w_exec) begin
            if (tok_kind == 2'd0) begin
                w_wr_en   = 1'b1;
                w_wr_data = tok_data;
            end else if (w_op == 5'd22) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_i3;
            end else if (w_op >= 5'd23) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_i1;
            end else if (w_op != 5'd0) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_i2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_stk[w_wr_idx] <= w_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_ACCEPT;
            r_tok_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_sp        <= '0;
            r_err       <= 1'b0;
            r_pa        <= '0;
            r_pb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_ACCEPT: begin
                    r_tok_ready <= 1'b1;
                    if (w_xfer) begin
                        if (tok_kind == 2'd2) begin
                            r_state     <= S_DONE;
                            r_tok_ready <= 1'b0;
                            r_res_valid <= 1'b1;
                            if (!r_err && r_sp == SW'(1)) begin
                                r_res_data <= r_stk[0];
                                r_res_err  <= 1'b0;
                            end else begin
                                r_res_data <= '0;
                                r_res_err  <= 1'b1;
                            end
                        end else if (!r_err) begin
                            if (w_bad_tok)
                                r_err <= 1'b1;
                            else if (tok_kind == 2'd0)
                                r_sp <= r_sp + SW'(1);
                            else if (w_op == 5'd0) begin
                                r_pa        <= w_a;
                                r_pb        <= w_b;
                                r_acc       <= WIDTH'(1);
                                r_cnt       <= CW'(WIDTH - 1);
                                r_sp        <= r_sp - SW'(2);
                                r_state     <= S_POW;
                                r_tok_ready <= 1'b0;
                            end else if (w_op == 5'd22)
                                r_sp <= r_sp - SW'(2);
                            else if (w_op <= 5'd21)
                                r_sp <= r_sp - SW'(1);
                        end
                    end
                end
                S_POW: begin
                    r_acc <= w_pow_n;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_sp        <= r_sp + SW'(1);
                        r_state     <= S_ACCEPT;
                        r_tok_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_data  <= '0;
                        r_res_err   <= 1'b0;
                        r_sp        <= '0;
                        r_err       <= 1'b0;
                        r_state     <= S_ACCEPT;
                        r_tok_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_ACCEPT;
                    r_tok_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
